// File: rtl/sm4_ck_gen_if.sv
// sm4_ck_gen_if -- handshake/bus bundle for the SM4 round-constant generator.
//   master : drives start/reverse/ck_ready/lookup_en/lookup_idx, observes outputs
//   slave  : the generator side
//   IDX_W  : width of ck_index and lookup_idx; must equal the generator's IDX_W
interface sm4_ck_gen_if #(
  parameter int IDX_W = 5
);
  logic             start;
  logic             reverse;
  logic             ck_ready;
  logic             ck_valid;
  logic [31:0]      ck_out;
  logic [IDX_W-1:0] ck_index;
  logic             busy;
  logic             done;
  logic             lookup_en;
  logic [IDX_W-1:0] lookup_idx;
  logic [31:0]      lookup_ck;

  modport master (
    output start, reverse, ck_ready, lookup_en, lookup_idx,
    input  ck_valid, ck_out, ck_index, busy, done, lookup_ck
  );

  modport slave (
    input  start, reverse, ck_ready, lookup_en, lookup_idx,
    output ck_valid, ck_out, ck_index, busy, done, lookup_ck
  );
endinterface

// File: rtl/sm4_ck_gen.sv
// sm4_ck_gen -- SM4 round-constant (CK) generator.
// Streams NUM_ROUNDS constants (forward or reverse) over a valid/ready
// handshake and offers an independent registered random-access lookup.
// Constant i = bytes b0..b3 (b0 in bits 31:24), bj = ((4*i+j)*CK_STEP) mod 256.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : sm4_ck_gen_if.slave (start, reverse, ck_ready, ck_valid, ck_out,
//          ck_index, busy, done, lookup_en, lookup_idx, lookup_ck)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no sequence active; outputs zero; start/reverse sampled here
// RUN   | ck_out/ck_index valid, advancing one constant per handshake
module sm4_ck_gen #(
  parameter int NUM_ROUNDS = 32,
  parameter int CK_STEP    = 7
) (
  input  logic        clk,
  input  logic        rst,
  sm4_ck_gen_if.slave bus
);

  localparam int IDX_W = (NUM_ROUNDS > 2) ? $clog2(NUM_ROUNDS) : 1;

  // Closed-form constant; only used for fixed start values and the lookup port.
  function automatic logic [31:0] ck_of(input int unsigned i);
    logic [31:0] r;
    r = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      r = {r[23:0], 8'((4 * i + j) * CK_STEP)};
    end
    return r;
  endfunction

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [31:0]      CK_FIRST = ck_of(0);
  localparam logic [31:0]      CK_LAST  = ck_of(NUM_ROUNDS - 1);
  localparam logic [7:0]       STEP4    = 8'(4 * CK_STEP);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             rev_q, rev_d;
  logic [31:0]      ck_q, ck_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [31:0]      lookup_q, lookup_d;

  logic hs;
  logic at_last;

  assign hs      = (state_q == RUN) && bus.ck_ready;
  assign at_last = rev_q ? (idx_q == '0) : (idx_q == IDX_LAST);

  // State register (all flops)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rev_q    <= 1'b0;
      ck_q     <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      lookup_q <= '0;
    end else begin
      state_q  <= state_d;
      rev_q    <= rev_d;
      ck_q     <= ck_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      lookup_q <= lookup_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (hs && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: the sequence advances by adding/subtracting a
  // fixed per-byte step, so no multiplier sits on this path.
  always_comb begin
    rev_d  = rev_q;
    ck_d   = ck_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        rev_d = bus.reverse;
        ck_d  = bus.reverse ? CK_LAST : CK_FIRST;
        idx_d = bus.reverse ? IDX_LAST : '0;
      end
    end else if (hs) begin
      if (at_last) begin
        done_d = 1'b1;
        ck_d   = '0;
        idx_d  = '0;
      end else begin
        for (int b = 0; b < 4; b++) begin
          ck_d[8*b +: 8] = rev_q ? (ck_q[8*b +: 8] - STEP4) : (ck_q[8*b +: 8] + STEP4);
        end
        idx_d = rev_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
      end
    end
  end

  // Random-access lookup, independent of the FSM; out-of-range loads zero.
  always_comb begin
    lookup_d = lookup_q;
    if (bus.lookup_en) begin
      lookup_d = (32'(bus.lookup_idx) < 32'(NUM_ROUNDS)) ? ck_of(32'(bus.lookup_idx)) : '0;
    end
  end

  // Outputs; sequence outputs are forced to zero whenever not valid.
  always_comb begin
    bus.ck_valid  = (state_q == RUN);
    bus.busy      = (state_q == RUN);
    bus.ck_out    = (state_q == RUN) ? ck_q : '0;
    bus.ck_index  = (state_q == RUN) ? idx_q : '0;
    bus.done      = done_q;
    bus.lookup_ck = lookup_q;
  end

endmodule

// File: tb/tb_sm4_ck_gen.sv
module tb_sm4_ck_gen;
  localparam int N    = 32;
  localparam int N2   = 20;
  localparam int STEP = 7;
  localparam int IW   = 5;
  localparam int IW2  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm4_ck_gen_if #(.IDX_W(IW))  bus ();
  sm4_ck_gen_if #(.IDX_W(IW2)) bus2 ();

  sm4_ck_gen #(.NUM_ROUNDS(N),  .CK_STEP(STEP)) dut   (.clk(clk), .rst(rst), .bus(bus));
  sm4_ck_gen #(.NUM_ROUNDS(N2), .CK_STEP(STEP)) dut20 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    int          idx;
    logic [31:0] ck;
    bit          last;
  } item_t;

  item_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 0;
  bit          pend_done = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by task
  logic [31:0] lk_exp   = '0;

  // Reference: constant i, byte j = ((4*i+j)*STEP) mod 256, byte 0 most significant.
  function automatic logic [31:0] model_ck(input int i);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r = (r << 8) | 32'(((4 * i + j) * STEP) % 256);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input bit rev);
    item_t it;
    for (int k = 0; k < N; k++) begin
      it.idx  = rev ? (N - 1 - k) : k;
      it.ck   = model_ck(it.idx);
      it.last = (k == N - 1);
      exp_q.push_back(it);
    end
  endtask

  // Monitor: compares every presented constant against the scoreboard.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (pend_done) begin
          check("done_pulse", 32'(bus.done), 32'd1);
          check("done_busy", 32'(bus.busy), 32'd0);
          pend_done = 0;
        end else begin
          check("no_done", 32'(bus.done), 32'd0);
        end
        if (bus.ck_valid) begin
          check("busy_run", 32'(bus.busy), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got ck_out %h with no expected item", bus.ck_out);
          end else begin
            it = exp_q[0];
            check("ck_out", bus.ck_out, it.ck);
            check("ck_index", 32'(bus.ck_index), 32'(it.idx));
            if (bus.ck_ready) begin
              it = exp_q.pop_front();
              if (it.last) pend_done = 1;
            end
          end
        end else begin
          check("idle_ck_out", bus.ck_out, 32'd0);
          check("idle_ck_index", 32'(bus.ck_index), 32'd0);
          check("idle_busy", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  // ck_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) bus.ck_ready = 1'b1;
      else if (rdy_mode == 1) bus.ck_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Wait until the scoreboard drains; returns at posedge+1 of the done cycle.
  task automatic drain(input bit spurious);
    int cyc;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
      if (spurious && exp_q.size() >= 2) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.reverse = 1'($urandom_range(0, 1));
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (cyc >= 600) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d items left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_seq(input bit rev, input bit spurious);
    push_seq(rev);
    bus.start   = 1'b1;
    bus.reverse = rev;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.reverse = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("first_valid_latency", 32'(bus.ck_valid), 32'd1);
    drain(spurious);
  endtask

  task automatic lookup_burst(input int n, input bit force9);
    for (int k = 0; k < n; k++) begin
      if (force9 && k == 3) begin
        bus.lookup_en  = 1'b1;
        bus.lookup_idx = IW'(9);
      end else begin
        bus.lookup_en  = 1'($urandom_range(0, 1));
        bus.lookup_idx = IW'($urandom_range(0, N - 1));
      end
      if (bus.lookup_en) lk_exp = model_ck(int'(bus.lookup_idx));
      @(posedge clk);
      #1;
      check("lookup_ck", bus.lookup_ck, lk_exp);
      if (force9 && k == 3) check("lookup_idx9", bus.lookup_ck, 32'hfc030a11);
    end
    bus.lookup_en = 1'b0;
  endtask

  task automatic backpressure();
    rdy_mode     = 2;
    bus.ck_ready = 1'b1;
    push_seq(0);
    bus.start    = 1'b1;
    bus.reverse  = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    bus.ck_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_ck", bus.ck_out, 32'h1c232a31);
      check("bp_hold_idx", 32'(bus.ck_index), 32'd1);
      check("bp_hold_valid", 32'(bus.ck_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.ck_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_next_ck", bus.ck_out, 32'h383f464d);
    check("bp_next_idx", 32'(bus.ck_index), 32'd2);
    rdy_mode = 0;
    drain(0);
  endtask

  task automatic reset_mid_run();
    rdy_mode     = 0;
    bus.ck_ready = 1'b1;
    push_seq(0);
    bus.start    = 1'b1;
    bus.reverse  = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("pre_reset_ck", bus.ck_out, 32'h8c939aa1);
    #2;
    mon_en = 0;
    rst    = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.ck_valid), 32'd0);
    check("async_rst_ck", bus.ck_out, 32'd0);
    check("async_rst_idx", 32'(bus.ck_index), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    check("async_rst_lookup", bus.lookup_ck, 32'd0);
    exp_q.delete();
    pend_done = 0;
    lk_exp    = '0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    run_seq(0, 0);
  endtask

  task automatic run20();
    bus2.ck_ready = 1'b1;
    bus2.start    = 1'b1;
    bus2.reverse  = 1'b0;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    for (int k = 0; k < N2; k++) begin
      @(negedge clk);
      check("n20_ck", bus2.ck_out, model_ck(k));
      check("n20_idx", 32'(bus2.ck_index), 32'(k));
      if (k == N2 - 1) check("n20_last_ck", bus2.ck_out, 32'h141b2229);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("n20_done", 32'(bus2.done), 32'd1);
    check("n20_valid_off", 32'(bus2.ck_valid), 32'd0);
    check("n20_busy_off", 32'(bus2.busy), 32'd0);
    @(posedge clk);
    #1;
    bus2.lookup_en  = 1'b1;
    bus2.lookup_idx = IW2'(19);
    @(posedge clk);
    #1;
    check("n20_lookup19", bus2.lookup_ck, model_ck(19));
    bus2.lookup_idx = IW2'(25);
    @(posedge clk);
    #1;
    check("n20_lookup25", bus2.lookup_ck, 32'd0);
    bus2.lookup_en = 1'b0;
    check("n20_done_single", 32'(bus2.done), 32'd0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.reverse     = 1'b0;
    bus.ck_ready    = 1'b1;
    bus.lookup_en   = 1'b0;
    bus.lookup_idx  = '0;
    bus2.start      = 1'b0;
    bus2.reverse    = 1'b0;
    bus2.ck_ready   = 1'b1;
    bus2.lookup_en  = 1'b0;
    bus2.lookup_idx = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.ck_valid), 32'd0);
    check("rst_ck", bus.ck_out, 32'd0);
    check("rst_idx", 32'(bus.ck_index), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_lookup", bus.lookup_ck, 32'd0);
    check("rst20_valid", 32'(bus2.ck_valid), 32'd0);
    rst    = 1'b0;
    mon_en = 1;
    @(posedge clk);
    #1;

    fork
      run_seq(0, 0);
      lookup_burst(40, 1);
    join
    repeat (2) @(posedge clk);
    #1;
    run_seq(1, 0);
    repeat (2) @(posedge clk);
    #1;
    backpressure();
    repeat (2) @(posedge clk);
    #1;
    run_seq(0, 0);
    run_seq(1, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_mid_run();

    rdy_mode = 1;
    for (int r = 0; r < 6; r++) begin
      fork
        run_seq(1'($urandom_range(0, 1)), 1);
        lookup_burst(30, 0);
      join
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    run20();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm4_ck_gen.md
SM4_CK_GEN -- requirements
Module: sm4_ck_gen

Interface
REQ-001 SHALL provide parameter NUM_ROUNDS, default 32, number of round constants per sequence (legal range 2..256).
REQ-002 SHALL provide parameter CK_STEP, default 7, per-byte increment of the constant series (8-bit).
REQ-003 SHALL derive IDX_W = max(1, clog2(NUM_ROUNDS)) as a local parameter.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; the port list SHALL start with clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  request a full constant sequence; sampled only in IDLE.
REQ-008 reverse  input  1  sampled with start; 0 = index 0 to NUM_ROUNDS-1, 1 = NUM_ROUNDS-1 to 0.
REQ-009 ck_ready  input  1  downstream accepts ck_out this cycle.
REQ-010 ck_valid  output  1  ck_out/ck_index valid.
REQ-011 ck_out  output  32  current round constant.
REQ-012 ck_index  output  IDX_W  round index of ck_out.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse after the last constant is accepted.
REQ-015 lookup_en  input  1  random-access lookup request.
REQ-016 lookup_idx  input  IDX_W  random-access index.
REQ-017 lookup_ck  output  32  registered random-access result.

Function
REQ-018 Constant for index i SHALL be bytes b0..b3 (b0 = bits 31:24), bj = ((4*i + j) * CK_STEP) mod 256.
REQ-019 FSM SHALL have states IDLE and RUN: IDLE->RUN on start; RUN->IDLE on handshake (ck_valid & ck_ready) at the final index; no other transitions except reset.
REQ-020 Latency: start in IDLE at cycle N SHALL give ck_valid=1 with the first constant at cycle N+1.
REQ-021 Forward first constant SHALL be index 0; reverse first constant SHALL be index NUM_ROUNDS-1.
REQ-022 On each handshake in RUN, the next constant SHALL be produced incrementally: each byte +4*CK_STEP mod 256 (forward) or -4*CK_STEP mod 256 (reverse); index +1 or -1. Multipliers SHALL NOT be used on this sequential path.
REQ-023 With ck_ready low, ck_out, ck_index and ck_valid SHALL hold unchanged.
REQ-024 The final handshake SHALL clear ck_valid and busy and pulse done for exactly one cycle on the next cycle.
REQ-025 start SHALL be ignored in RUN; reverse SHALL be ignored unless sampled with an accepted start.
REQ-026 start asserted in the cycle done is high SHALL be accepted (back-to-back sequences, one idle cycle between).
REQ-027 When ck_valid is low, ck_out and ck_index SHALL be 0.
REQ-028 lookup_ck SHALL load the REQ-018 value of lookup_idx one cycle after lookup_en=1, and hold when lookup_en=0.
REQ-029 lookup_idx >= NUM_ROUNDS SHALL load lookup_ck = 32'h0.
REQ-030 The lookup port SHALL operate independently of and concurrently with the FSM.

Reset
REQ-031 rst SHALL force IDLE immediately, independent of clk.
REQ-032 Reset values: ck_valid=0, ck_out=0, ck_index=0, busy=0, done=0, lookup_ck=0.
REQ-033 rst asserted mid-sequence SHALL abort it with no done pulse; the first start after reset release SHALL begin a fresh sequence.

Verification
REQ-034 Forward run, ck_ready=1: start -> 32 consecutive constants 00070e15, 1c232a31, 383f464d ... 646b7279 at indices 0..31, then done pulse, busy=0.
REQ-035 Reverse run: start with reverse=1 -> 646b7279 (idx 31), 484f565d (idx 30) ... 00070e15 (idx 0), then done.
REQ-036 Backpressure: ck_ready low for 3 cycles while showing idx 1 -> ck_out holds 1c232a31, idx 2 (383f464d) appears only after ck_ready returns.
REQ-037 Lookup: lookup_en=1, lookup_idx=9 during a forward run -> lookup_ck=fc030a11 next cycle; sequence output unaffected.
REQ-038 Reset mid-run at idx 5 (8c939aa1) -> all outputs 0 asynchronously, no done; a new start yields 00070e15.
REQ-039 NUM_ROUNDS=20: forward run ends at idx 19 with 141b2229 then done; lookup_idx=25 -> lookup_ck=0.
